motor_command_parser: RTL and testbench



---
 rtl/motor_command_parser_if.sv | 10 +
 rtl/motor_command_parser.sv | 188 ++++++++++++++++++
 tb/tb_motor_command_parser.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/motor_command_parser_if.sv
// UART receiver to command-parser byte handshake.
// A byte is consumed when rdy is high and rdy_clr is low; rdy_clr answers one cycle later.
interface motor_command_parser_if;
  logic       rdy;
  logic [7:0] dout;
  logic       rdy_clr;

  modport master (output rdy, output dout, input rdy_clr);
  modport slave  (input rdy, input dout, output rdy_clr);
endinterface

// File: rtl/motor_command_parser.sv
// Multi-channel UART motor command parser: frames of <letter><digits><# or !>
// update one channel's speed and signed direction; malformed frames report an error code.
module motor_command_parser #(
  parameter int                  NUM_CH      = 2,
  parameter int                  VAL_W       = 8,
  parameter int                  MAX_DIGITS  = 3,
  parameter logic [NUM_CH*8-1:0] LETTERS     = {8'd66, 8'd65},
  parameter logic [7:0]          TERM_FWD    = 8'd35,
  parameter logic [7:0]          TERM_REV    = 8'd33,
  parameter int                  TIMEOUT_CYC = 5_000_000,
  localparam int                 CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  motor_command_parser_if.slave     uart,
  output logic [NUM_CH*VAL_W-1:0]   SALIDA_AL_MOTOR,
  output logic [NUM_CH*2-1:0]       SALIDA_DIRECCION,
  output logic                      CMD_VALID,
  output logic [CH_W-1:0]           CMD_CH,
  output logic                      ERR,
  output logic [2:0]                ERR_CODE
);

  localparam int ACC_W = VAL_W + 4;
  localparam int CNT_W = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ACC_W-1:0] MAX_VAL  = {{4{1'b0}}, {VAL_W{1'b1}}};
  localparam logic [ACC_W-1:0] TEN      = ACC_W'(10);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] E_BAD_BYTE  = 3'd1;
  localparam logic [2:0] E_DIGITS    = 3'd2;
  localparam logic [2:0] E_OVERFLOW  = 3'd3;
  localparam logic [2:0] E_TIMEOUT   = 3'd4;
  localparam logic [2:0] E_NO_DIGITS = 3'd5;

  typedef enum logic {IDLE, DIGITS} state_t;

  state_t           state_reg;
  logic [CH_W-1:0]  ch_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [TMR_W-1:0] tmr_reg;
  logic             rdy_clr_reg;
  logic             cmd_valid_reg;
  logic [CH_W-1:0]  cmd_ch_reg;
  logic             err_reg;
  logic [2:0]       err_code_reg;

  logic             accept;
  logic             is_digit;
  logic             is_term;
  logic             commit;
  logic [NUM_CH-1:0] letter_hit;
  logic             any_letter;
  logic [CH_W-1:0]  hit_idx;
  logic [ACC_W-1:0] acc_next;

  assign accept   = uart.rdy && !rdy_clr_reg;
  assign is_digit = (uart.dout >= 8'd48) && (uart.dout <= 8'd57);
  assign is_term  = (uart.dout == TERM_FWD) || (uart.dout == TERM_REV);
  assign acc_next = acc_reg * TEN + ACC_W'(uart.dout - 8'd48);
  assign commit   = accept && (state_reg == DIGITS) && !is_digit && is_term && (cnt_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_match
      assign letter_hit[gi] = (uart.dout == LETTERS[8*gi +: 8]);
    end
  endgenerate

  assign any_letter = |letter_hit;

  // Scan downward so the lowest-numbered matching channel wins on duplicated letters.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (letter_hit[i]) begin
        hit_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      tmr_reg       <= '0;
      rdy_clr_reg   <= 1'b0;
      cmd_valid_reg <= 1'b0;
      cmd_ch_reg    <= '0;
      err_reg       <= 1'b0;
      err_code_reg  <= '0;
    end else begin
      rdy_clr_reg   <= accept;
      cmd_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          tmr_reg <= '0;
          if (accept && any_letter) begin
            state_reg <= DIGITS;
            ch_reg    <= hit_idx;
            acc_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        DIGITS: begin
          if (accept) begin
            tmr_reg <= '0;
            if (is_digit) begin
              if (cnt_reg == CNT_MAX) begin
                err_reg      <= 1'b1;
                err_code_reg <= E_DIGITS;
                state_reg    <= IDLE;
              end else if (acc_next > MAX_VAL) begin
                err_reg      <= 1'b1;
                err_code_reg <= E_OVERFLOW;
                state_reg    <= IDLE;
              end else begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_reg + 1'b1;
              end
            end else if (is_term) begin
              if (cnt_reg == '0) begin
                err_reg      <= 1'b1;
                err_code_reg <= E_NO_DIGITS;
              end else begin
                cmd_valid_reg <= 1'b1;
                cmd_ch_reg    <= ch_reg;
              end
              state_reg <= IDLE;
            end else if (any_letter) begin
              // Abandon the open frame but start the new one on this same byte.
              err_reg      <= 1'b1;
              err_code_reg <= E_BAD_BYTE;
              ch_reg       <= hit_idx;
              acc_reg      <= '0;
              cnt_reg      <= '0;
            end else begin
              err_reg      <= 1'b1;
              err_code_reg <= E_BAD_BYTE;
              state_reg    <= IDLE;
            end
          end else if (tmr_reg == TMR_LAST) begin
            err_reg      <= 1'b1;
            err_code_reg <= E_TIMEOUT;
            tmr_reg      <= '0;
            state_reg    <= IDLE;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [VAL_W-1:0] speed_reg;
      logic [1:0]       dir_reg;

      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          speed_reg <= '0;
          dir_reg   <= 2'b00;
        end else if (commit && (ch_reg == CH_W'(gi))) begin
          speed_reg <= acc_reg[VAL_W-1:0];
          dir_reg   <= (uart.dout == TERM_FWD) ? 2'b01 : 2'b11;
        end
      end

      assign SALIDA_AL_MOTOR[VAL_W*gi +: VAL_W] = speed_reg;
      assign SALIDA_DIRECCION[2*gi +: 2]        = dir_reg;
    end
  endgenerate

  assign uart.rdy_clr = rdy_clr_reg;
  assign CMD_VALID    = cmd_valid_reg;
  assign CMD_CH       = cmd_ch_reg;
  assign ERR          = err_reg;
  assign ERR_CODE     = err_code_reg;

endmodule

// File: tb/tb_motor_command_parser.sv
// Directed bench for motor_command_parser: byte table with expected outputs,
// plus hand-written timeout, accept-vs-timeout and mid-frame reset sequences.
module tb_motor_command_parser;

  logic        CLOCK_50;
  logic        RESET;
  logic [15:0] SALIDA_AL_MOTOR;
  logic [3:0]  SALIDA_DIRECCION;
  logic        CMD_VALID;
  logic [0:0]  CMD_CH;
  logic        ERR;
  logic [2:0]  ERR_CODE;

  int checks   = 0;
  int failures = 0;

  motor_command_parser_if uart_if ();

  motor_command_parser #(
    .NUM_CH      (2),
    .VAL_W       (8),
    .MAX_DIGITS  (3),
    .LETTERS     ({8'd66, 8'd65}),
    .TERM_FWD    (8'd35),
    .TERM_REV    (8'd33),
    .TIMEOUT_CYC (20)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .RESET            (RESET),
    .uart             (uart_if.slave),
    .SALIDA_AL_MOTOR  (SALIDA_AL_MOTOR),
    .SALIDA_DIRECCION (SALIDA_DIRECCION),
    .CMD_VALID        (CMD_VALID),
    .CMD_CH           (CMD_CH),
    .ERR              (ERR),
    .ERR_CODE         (ERR_CODE)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Observation word: {valid, err, code[2:0], ch, speed[15:0], dir[3:0]}
  typedef struct {
    logic [7:0]  b;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [25:0] mk(input logic v, input logic e, input logic [2:0] c,
                                     input logic ch, input logic [15:0] s, input logic [3:0] d);
    return {v, e, c, ch, s, d};
  endfunction

  function automatic logic [25:0] obs();
    return {CMD_VALID, ERR, ERR_CODE, CMD_CH, SALIDA_AL_MOTOR, SALIDA_DIRECCION};
  endfunction

  task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one byte for a cycle; outputs of the byte are visible at the return point.
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    uart_if.rdy  = 1'b1;
    uart_if.dout = b;
    @(negedge CLOCK_50);
    checks++;
    if (uart_if.rdy_clr !== 1'b1) begin
      failures++;
      $display("FAIL rdy_clr byte=%h actual=%b required=1", b, uart_if.rdy_clr);
    end
    uart_if.rdy = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] b, input logic [25:0] exp, input string name);
    send(b);
    $display("byte %h (%s) obs=%h exp=%h", b, name, obs(), exp);
    chk(name, obs(), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    logic seen;
    logic errs;

    // Commit A128#, commit B7!, overflow, too many digits, empty frame, bad byte,
    // letter switch mid-frame, value 0, and exact maximum 255 with 3 digits.
    tbl.push_back('{8'h41, mk(0,0,3'd0,0,16'h0000,4'h0)});
    tbl.push_back('{8'h31, mk(0,0,3'd0,0,16'h0000,4'h0)});
    tbl.push_back('{8'h32, mk(0,0,3'd0,0,16'h0000,4'h0)});
    tbl.push_back('{8'h38, mk(0,0,3'd0,0,16'h0000,4'h0)});
    tbl.push_back('{8'h23, mk(1,0,3'd0,0,16'h0080,4'h1)});
    tbl.push_back('{8'h42, mk(0,0,3'd0,0,16'h0080,4'h1)});
    tbl.push_back('{8'h37, mk(0,0,3'd0,0,16'h0080,4'h1)});
    tbl.push_back('{8'h21, mk(1,0,3'd0,1,16'h0780,4'hD)});
    tbl.push_back('{8'h41, mk(0,0,3'd0,1,16'h0780,4'hD)});
    tbl.push_back('{8'h32, mk(0,0,3'd0,1,16'h0780,4'hD)});
    tbl.push_back('{8'h35, mk(0,0,3'd0,1,16'h0780,4'hD)});
    tbl.push_back('{8'h36, mk(0,1,3'd3,1,16'h0780,4'hD)});
    tbl.push_back('{8'h23, mk(0,0,3'd3,1,16'h0780,4'hD)});
    tbl.push_back('{8'h41, mk(0,0,3'd3,1,16'h0780,4'hD)});
    tbl.push_back('{8'h30, mk(0,0,3'd3,1,16'h0780,4'hD)});
    tbl.push_back('{8'h30, mk(0,0,3'd3,1,16'h0780,4'hD)});
    tbl.push_back('{8'h31, mk(0,0,3'd3,1,16'h0780,4'hD)});
    tbl.push_back('{8'h32, mk(0,1,3'd2,1,16'h0780,4'hD)});
    tbl.push_back('{8'h23, mk(0,0,3'd2,1,16'h0780,4'hD)});
    tbl.push_back('{8'h41, mk(0,0,3'd2,1,16'h0780,4'hD)});
    tbl.push_back('{8'h23, mk(0,1,3'd5,1,16'h0780,4'hD)});
    tbl.push_back('{8'h41, mk(0,0,3'd5,1,16'h0780,4'hD)});
    tbl.push_back('{8'h31, mk(0,0,3'd5,1,16'h0780,4'hD)});
    tbl.push_back('{8'h78, mk(0,1,3'd1,1,16'h0780,4'hD)});
    tbl.push_back('{8'h41, mk(0,0,3'd1,1,16'h0780,4'hD)});
    tbl.push_back('{8'h34, mk(0,0,3'd1,1,16'h0780,4'hD)});
    tbl.push_back('{8'h42, mk(0,1,3'd1,1,16'h0780,4'hD)});
    tbl.push_back('{8'h39, mk(0,0,3'd1,1,16'h0780,4'hD)});
    tbl.push_back('{8'h23, mk(1,0,3'd1,1,16'h0980,4'h5)});
    tbl.push_back('{8'h42, mk(0,0,3'd1,1,16'h0980,4'h5)});
    tbl.push_back('{8'h30, mk(0,0,3'd1,1,16'h0980,4'h5)});
    tbl.push_back('{8'h21, mk(1,0,3'd1,1,16'h0080,4'hD)});
    tbl.push_back('{8'h41, mk(0,0,3'd1,1,16'h0080,4'hD)});
    tbl.push_back('{8'h32, mk(0,0,3'd1,1,16'h0080,4'hD)});
    tbl.push_back('{8'h35, mk(0,0,3'd1,1,16'h0080,4'hD)});
    tbl.push_back('{8'h35, mk(0,0,3'd1,1,16'h0080,4'hD)});
    tbl.push_back('{8'h21, mk(1,0,3'd1,0,16'h00FF,4'hF)});

    RESET        = 1'b1;
    uart_if.rdy  = 1'b0;
    uart_if.dout = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    chk("reset_outputs", obs(), 26'h0);
    checks++;
    if (uart_if.rdy_clr !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_clr actual=%b required=0", uart_if.rdy_clr);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      send_chk(tbl[i].b, tbl[i].exp, $sformatf("row%0d", i));
    end

    // Inter-byte timeout: error must appear on the 20th idle cycle; a late '#' is dropped.
    send_chk(8'h41, mk(0,0,3'd1,0,16'h00FF,4'hF), "to_A");
    send_chk(8'h35, mk(0,0,3'd1,0,16'h00FF,4'hF), "to_5");
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge CLOCK_50);
      k++;
      if (ERR === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || k != 20) begin
      failures++;
      $display("FAIL timeout_cycle actual=%0d seen=%b required=20", k, seen);
    end
    $display("timeout err after %0d idle cycles", k);
    chk("timeout_err", obs(), mk(0,1,3'd4,0,16'h00FF,4'hF));
    send_chk(8'h23, mk(0,0,3'd4,0,16'h00FF,4'hF), "to_late_term");

    // An accept landing on the timeout cycle must win.
    send_chk(8'h41, mk(0,0,3'd4,0,16'h00FF,4'hF), "race_A");
    send_chk(8'h35, mk(0,0,3'd4,0,16'h00FF,4'hF), "race_5");
    errs = 1'b0;
    repeat (18) begin
      @(negedge CLOCK_50);
      if (ERR === 1'b1) errs = 1'b1;
    end
    checks++;
    if (errs !== 1'b0) begin
      failures++;
      $display("FAIL race_early_err actual=%b required=0", errs);
    end
    send_chk(8'h23, mk(1,0,3'd4,0,16'h0005,4'hD), "race_term");

    // Reset in the middle of a frame clears everything and discards the rest of it.
    send_chk(8'h41, mk(0,0,3'd4,0,16'h0005,4'hD), "rst_A");
    send_chk(8'h33, mk(0,0,3'd4,0,16'h0005,4'hD), "rst_3");
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    RESET = 1'b0;
    chk("midreset_outputs", obs(), 26'h0);
    checks++;
    if (uart_if.rdy_clr !== 1'b0) begin
      failures++;
      $display("FAIL midreset_rdy_clr actual=%b required=0", uart_if.rdy_clr);
    end
    send_chk(8'h33, 26'h0, "post_rst_3");
    send_chk(8'h23, 26'h0, "post_rst_term");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
